sm510_core: RTL and testbench

// Cycle-stepped Sharp SM510 4-bit microcontroller core for the Game & Watch platform.
// - Fetches 8-bit opcodes from external ROM, executes the SM510 instruction set against 128x4 internal RAM.
// - Scans the key matrix through the W shifter and R outputs.
// - Keeps a 15-bit 32.768 kHz time-base divider.
// - All state advances only on clk_en; the system clock is much faster.

---
 rtl/sm510_core.sv | 217 +++++++++++++++++++++
 tb/tb_sm510_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sm510_core.sv
// Sharp SM510 4-bit MCU core: stage-sequenced fetch/execute against 128x4 RAM,
// W/R key-scan outputs and the 15-bit time-base divider, all advanced by clk_en.
module sm510_core #(
    parameter logic [11:0] RESET_PC = 12'hDC0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [3:0]  cpu_id,
    input  logic [7:0]  rom_data,
    output logic [11:0] rom_addr,
    input  logic [3:0]  input_k,
    input  logic        input_ba,
    input  logic        input_beta,
    output logic [7:0]  output_shifter_s,
    output logic [3:0]  output_r,
    input  logic        accurate_lcd_timing
);
    typedef enum logic [2:0] {
        LOAD_PC  = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        OP_LOAD  = 3'd3,
        OP_FETCH = 3'd4
    } stage_t;

    stage_t      stage, stage_next;
    logic [11:0] pc, stack_s, stack_r;
    logic [7:0]  opcode, last_opcode, operand, shifter_w;
    logic [3:0]  acc, bl, r, y_reg, l_reg;
    logic [2:0]  bm;
    logic        carry, gamma, skip, sbm, bp, bc;
    logic [14:0] divider;
    logic [3:0]  ram [0:127];

    logic [6:0]  ram_addr;
    logic [3:0]  m, bit_mask, ram_wdata;
    logic        ram_we, suppress, fetch_two;
    logic [4:0]  add11_sum, adx_sum;
    logic [11:0] pc_inc;

    // Pl steps as a 6-bit LFSR; Pu/Pm are untouched by sequential fetch.
    assign pc_inc    = {pc[11:6], ~(pc[0] ^ pc[1]), pc[5:1]};
    assign ram_addr  = {bm[2] | sbm, bm[1:0], bl};
    assign m         = ram[ram_addr];
    assign bit_mask  = 4'b0001 << opcode[1:0];
    assign add11_sum = {1'b0, acc} + {1'b0, m} + {4'd0, carry};
    assign adx_sum   = {1'b0, acc} + {1'b0, opcode[3:0]};
    assign suppress  = skip || (opcode[7:4] == 4'h2 && last_opcode[7:4] == 4'h2);
    assign fetch_two = (rom_data == 8'h5F) || (rom_data[7:4] == 4'h7) || (rom_data[7:6] == 2'b11);

    // TM reads its vector byte from page 0 during the operand fetch.
    assign rom_addr = ((stage == OP_LOAD || stage == OP_FETCH) && opcode[7:6] == 2'b11)
                      ? {6'd0, opcode[5:0]} : pc;
    assign output_shifter_s = shifter_w;
    assign output_r         = r;

    logic unused_ok;
    assign unused_ok = ^{cpu_id, accurate_lcd_timing, bp, bc, y_reg, l_reg, last_opcode[3:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stage <= LOAD_PC;
        else       stage <= stage_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        stage_next = stage;
        if (clk_en) begin
            case (stage)
                LOAD_PC:  stage_next = DECODE;
                DECODE:   stage_next = fetch_two ? OP_LOAD : EXEC;
                OP_LOAD:  stage_next = OP_FETCH;
                OP_FETCH: stage_next = EXEC;
                default:  stage_next = LOAD_PC;
            endcase
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = m;
        if (clk_en && stage == EXEC && !suppress) begin
            casez (opcode)
                8'b0000_01??: begin ram_we = 1'b1; ram_wdata = m & ~bit_mask; end
                8'b0000_11??: begin ram_we = 1'b1; ram_wdata = m | bit_mask;  end
                8'b0001_????: begin ram_we = (opcode[3:2] != 2'b10); ram_wdata = acc; end
                default: ;
            endcase
        end
    end

    // NOTE: RAM has no reset; it powers up undefined and firmware initialises it.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    // NOTE: all state uses non-blocking assignments; later writes in this block override earlier ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            stack_s     <= '0;
            stack_r     <= '0;
            opcode      <= '0;
            last_opcode <= '0;
            operand     <= '0;
            shifter_w   <= '0;
            acc         <= '0;
            bl          <= '0;
            r           <= '0;
            y_reg       <= '0;
            l_reg       <= '0;
            bm          <= '0;
            carry       <= 1'b0;
            gamma       <= 1'b0;
            skip        <= 1'b0;
            sbm         <= 1'b0;
            bp          <= 1'b0;
            bc          <= 1'b0;
            divider     <= '0;
        end else if (clk_en) begin
            divider <= divider + 15'd1;
            if (divider == 15'h7FFF) gamma <= 1'b1;
            case (stage)
                DECODE: begin
                    last_opcode <= opcode;
                    opcode      <= rom_data;
                    pc          <= pc_inc;
                end
                OP_FETCH: begin
                    operand <= rom_data;
                    if (opcode[7:6] != 2'b11) pc <= pc_inc;
                end
                EXEC: begin
                    skip <= 1'b0;
                    sbm  <= 1'b0;
                    if (!suppress) begin
                        casez (opcode)
                            8'h01: bp <= acc[0];
                            8'h02: sbm <= 1'b1;
                            8'h03: pc <= {pc[11:4], acc};
                            8'h08: acc <= acc + m;
                            8'h09: begin
                                acc   <= add11_sum[3:0];
                                carry <= add11_sum[4];
                                skip  <= add11_sum[4];
                            end
                            8'h0A: acc <= ~acc;
                            8'h0B: begin acc <= bl; bl <= acc; end
                            8'b0001_????: begin
                                acc <= m;
                                bm  <= bm ^ {1'b0, opcode[1:0]};
                                if (opcode[3:2] == 2'b01) begin
                                    bl <= bl + 4'd1; skip <= (bl == 4'hF);
                                end else if (opcode[3:2] == 2'b11) begin
                                    bl <= bl - 4'd1; skip <= (bl == 4'h0);
                                end
                            end
                            8'b0010_????: acc <= opcode[3:0];
                            8'b0011_????: begin
                                acc  <= adx_sum[3:0];
                                skip <= adx_sum[4] && (opcode[3:0] != 4'hA);
                            end
                            8'b0100_????: begin
                                bm <= {bm[2] | sbm, opcode[1:0]};
                                bl <= {{2{|opcode[3:2]}}, opcode[3:2]};
                            end
                            8'h50: skip <= !input_beta;
                            8'h51: skip <= !carry;
                            8'h52: skip <= (acc == m);
                            8'b0101_01??: skip <= m[opcode[1:0]];
                            8'h58: begin skip <= !gamma; gamma <= 1'b0; end
                            8'h59: l_reg <= acc;
                            8'h5A: skip <= (acc == 4'h0);
                            8'h5B: skip <= (acc == bl);
                            8'h5E: skip <= !input_ba;
                            8'h5F: begin bm <= operand[6:4]; bl <= operand[3:0]; end
                            8'h60: y_reg <= acc;
                            8'h61: r <= acc;
                            8'h62: shifter_w <= {shifter_w[6:0], 1'b0};
                            8'h63: shifter_w <= {shifter_w[6:0], 1'b1};
                            8'h64: begin bl <= bl + 4'd1; skip <= (bl == 4'hF); end
                            8'h65: divider <= '0;
                            8'h66: carry <= 1'b0;
                            8'h67: carry <= 1'b1;
                            8'h68: skip <= divider[14];
                            8'h69: skip <= divider[11];
                            8'h6A: acc <= input_k;
                            8'h6B: {acc, carry} <= {carry, acc};
                            8'h6C: begin bl <= bl - 4'd1; skip <= (bl == 4'h0); end
                            8'h6D: bc <= carry;
                            8'b0110_111?: begin
                                pc      <= stack_s;
                                stack_s <= stack_r;
                                skip    <= opcode[0];
                            end
                            8'b0111_11??: begin
                                stack_r <= stack_s;
                                stack_s <= pc;
                                pc      <= {operand[7:6], 2'b00, opcode[1:0], operand[5:0]};
                            end
                            8'b0111_????: pc <= {operand[7:6], opcode[3:0], operand[5:0]};
                            8'b10??_????: pc <= {pc[11:6], opcode[5:0]};
                            8'b11??_????: begin
                                stack_r <= stack_s;
                                stack_s <= pc;
                                pc      <= {2'b00, 4'h4, operand[5:0]};
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sm510_core.sv
// Scoreboarded bench for sm510_core: small programs in a bench-owned ROM, with
// expected port values queued up front and compared once the program settles.
module tb_sm510_core;
    localparam int SEL_ADDR = 0;
    localparam int SEL_W    = 1;
    localparam int SEL_R    = 2;

    logic        clk = 1'b0;
    logic        reset, clk_en, input_ba, input_beta, accurate_lcd_timing;
    logic [3:0]  cpu_id, input_k, output_r;
    logic [7:0]  rom_data, output_shifter_s;
    logic [11:0] rom_addr;

    logic [7:0]  rom [0:4095];
    logic [5:0]  seq [0:63];
    logic [7:0]  prog_q [$];

    string       tag_q  [$];
    int          sel_q  [$];
    int          wait_q [$];
    logic [11:0] val_q  [$];

    int n_checks = 0;
    int n_fail   = 0;

    sm510_core dut (
        .clk                 (clk),
        .reset               (reset),
        .clk_en              (clk_en),
        .cpu_id              (cpu_id),
        .rom_data            (rom_data),
        .rom_addr            (rom_addr),
        .input_k             (input_k),
        .input_ba            (input_ba),
        .input_beta          (input_beta),
        .output_shifter_s    (output_shifter_s),
        .output_r            (output_r),
        .accurate_lcd_timing (accurate_lcd_timing)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    function automatic logic [5:0] pl_next(input logic [5:0] p);
        return {~(p[0] ^ p[1]), p[5:1]};
    endfunction

    function automatic logic [11:0] observe(input int sel);
        case (sel)
            SEL_ADDR: return rom_addr;
            SEL_W:    return {4'd0, output_shifter_s};
            default:  return {8'd0, output_r};
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] actual, input logic [11:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string tag, input int sel, input logic [11:0] value, input int cycles);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        val_q.push_back(value);
        wait_q.push_back(cycles);
    endtask

    task automatic drain();
        while (tag_q.size() > 0) begin
            string       tag;
            int          sel, cycles;
            logic [11:0] value;
            tag    = tag_q.pop_front();
            sel    = sel_q.pop_front();
            value  = val_q.pop_front();
            cycles = wait_q.pop_front();
            if (cycles > 0) run(cycles);
            check(tag, observe(sel), value);
        end
    endtask

    // Program bytes go to the LFSR fetch order from DC0, followed by a T-to-self loop.
    task automatic load_prog();
        int n;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        n = prog_q.size();
        for (int i = 0; i < n; i++) rom[{6'h37, seq[i]}] = prog_q[i];
        rom[{6'h37, seq[n]}] = {2'b10, seq[n]};
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b1;
        run(2);
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        seq[0] = 6'h00;
        for (int i = 1; i < 64; i++) seq[i] = pl_next(seq[i-1]);

        reset = 1'b1; clk_en = 1'b1; cpu_id = 4'd4; input_k = 4'd0;
        input_ba = 1'b0; input_beta = 1'b0; accurate_lcd_timing = 1'b0;
        prog_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog();
        run(3);

        expect_at("reset_rom_addr", SEL_ADDR, 12'hDC0, 0);
        expect_at("reset_shifter", SEL_W, 12'h000, 0);
        expect_at("reset_r", SEL_R, 12'h000, 0);
        drain();

        clk_en = 1'b0;
        @(negedge clk) reset = 1'b0;
        expect_at("gated_rom_addr", SEL_ADDR, 12'hDC0, 10);
        drain();
        @(negedge clk) clk_en = 1'b1;
        expect_at("fetch0", SEL_ADDR, 12'hDC0, 1);
        expect_at("fetch1", SEL_ADDR, 12'hDE0, 1);
        expect_at("fetch2", SEL_ADDR, 12'hDF0, 3);
        expect_at("fetch3", SEL_ADDR, 12'hDF8, 3);
        drain();

        prog_q = '{8'h21, 8'h25, 8'h61};
        load_prog(); pulse_reset();
        expect_at("lax_chain_r", SEL_R, 12'h001, 150);
        drain();

        prog_q = '{8'h21, 8'h61, 8'h25, 8'h61};
        load_prog(); pulse_reset();
        expect_at("lax_split_r", SEL_R, 12'h005, 150);
        drain();

        prog_q = '{8'h63, 8'h62};
        load_prog(); pulse_reset();
        expect_at("ws_wr_shifter", SEL_W, 12'h002, 150);
        drain();

        input_k = 4'd4;
        prog_q = '{8'h6A, 8'h61};
        load_prog(); pulse_reset();
        expect_at("kta_4_r", SEL_R, 12'h004, 150);
        drain();

        input_k = 4'hB;
        load_prog(); pulse_reset();
        expect_at("kta_b_r", SEL_R, 12'h00B, 150);
        drain();

        prog_q = '{8'h40, 8'h21, 8'h10, 8'h66, 8'h2F, 8'h09, 8'h63, 8'h51, 8'h63, 8'h31, 8'h61};
        load_prog(); pulse_reset();
        expect_at("add11_shifter", SEL_W, 12'h001, 150);
        expect_at("add11_r", SEL_R, 12'h001, 0);
        drain();

        prog_q = '{8'h29, 8'h39, 8'h63, 8'h61};
        load_prog(); pulse_reset();
        expect_at("adx_skip_shifter", SEL_W, 12'h000, 150);
        expect_at("adx_skip_r", SEL_R, 12'h002, 0);
        drain();

        prog_q = '{8'h28, 8'h3A, 8'h63, 8'h61};
        load_prog(); pulse_reset();
        expect_at("adx10_shifter", SEL_W, 12'h001, 150);
        expect_at("adx10_r", SEL_R, 12'h002, 0);
        drain();

        prog_q = '{8'h7C, 8'h00, 8'h62, 8'h63};
        load_prog();
        rom[12'h000] = 8'h63;
        rom[12'h020] = 8'h6F;
        pulse_reset();
        expect_at("tml_rtn1_shifter", SEL_W, 12'h003, 150);
        drain();

        prog_q = '{8'h58, 8'h63, 8'h63};
        load_prog(); pulse_reset();
        expect_at("tis_gamma0_shifter", SEL_W, 12'h001, 150);
        drain();

        input_k = 4'd5;
        prog_q = '{8'h6A, 8'h61};
        for (int i = 0; i < 10; i++) prog_q.push_back(8'h63);
        load_prog(); pulse_reset();
        run(30);
        #3 reset = 1'b1;
        #1;
        expect_at("async_reset_rom_addr", SEL_ADDR, 12'hDC0, 0);
        expect_at("async_reset_shifter", SEL_W, 12'h000, 0);
        expect_at("async_reset_r", SEL_R, 12'h000, 0);
        drain();
        @(negedge clk) reset = 1'b0;
        expect_at("rerun_shifter", SEL_W, 12'h0FF, 150);
        expect_at("rerun_r", SEL_R, 12'h005, 0);
        drain();

        input_beta = 1'b1;
        prog_q = '{8'h50, 8'h80, 8'h58, 8'h63, 8'h58, 8'h63};
        load_prog(); pulse_reset();
        run(33000);
        @(negedge clk) input_beta = 1'b0;
        expect_at("gamma_tis_shifter", SEL_W, 12'h001, 150);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
